// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC owner: branch/jump redirect, flush strobes, pending replay
// Optional counters enabled by defining PC_REDIRECT_STATS_EN.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_ready_i,
    input  logic        stall_i,
    input  logic        id_jump_i,
    input  logic [31:0] id_jump_target_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_branch_i,
    input  logic [31:0] ex_branch_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
`ifdef PC_REDIRECT_STATS_EN
    output logic [31:0] br_taken_cnt_o,
    output logic [31:0] flush_cyc_cnt_o,
`endif
    output logic        redirect_pend_o
);

    typedef enum logic {ST_RUN, ST_PEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        take_br, take_j;

    assign take_br = ex_is_branch_i & ex_branch_i;
    // The EX branch is older than the ID jump, so it always wins.
    assign take_j  = id_jump_i & ~take_br;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        flush_ifid_o  = 1'b0;
        flush_idex_o  = 1'b0;
        case (state_q)
            ST_RUN: begin
                flush_ifid_o = take_br | take_j;
                flush_idex_o = take_br;
                if (take_br && imem_ready_i) begin
                    pc_d = ex_branch_target_i;
                end else if (take_j && imem_ready_i) begin
                    pc_d = id_jump_target_i;
                end else if (take_br || take_j) begin
                    pend_target_d = take_br ? ex_branch_target_i : id_jump_target_i;
                    state_d       = ST_PEND;
                end else if (!stall_i && imem_ready_i) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            ST_PEND: begin
                flush_idex_o = take_br;
                flush_ifid_o = take_br | imem_ready_i;
                if (take_br) begin
                    pend_target_d = ex_branch_target_i;
                end
                // A branch resolving in the replay cycle is newer than the latched target.
                if (imem_ready_i) begin
                    pc_d    = take_br ? ex_branch_target_i : pend_target_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc_o            = pc_q;
    assign pc_plus4_o      = pc_q + PC_STEP;
    assign redirect_pend_o = (state_q == ST_PEND);

`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] br_taken_cnt_q, flush_cyc_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_cnt_q  <= 32'd0;
            flush_cyc_cnt_q <= 32'd0;
        end else begin
            if (take_br) begin
                br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
            end
            if (flush_ifid_o || flush_idex_o) begin
                flush_cyc_cnt_q <= flush_cyc_cnt_q + 32'd1;
            end
        end
    end

    assign br_taken_cnt_o  = br_taken_cnt_q;
    assign flush_cyc_cnt_o = flush_cyc_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready_i;
    logic        stall_i;
    logic        id_jump_i;
    logic [31:0] id_jump_target_i;
    logic        ex_is_branch_i;
    logic        ex_branch_i;
    logic [31:0] ex_branch_target_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic        redirect_pend_o;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] br_taken_cnt_o;
    logic [31:0] flush_cyc_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .imem_ready_i       (imem_ready_i),
        .stall_i            (stall_i),
        .id_jump_i          (id_jump_i),
        .id_jump_target_i   (id_jump_target_i),
        .ex_is_branch_i     (ex_is_branch_i),
        .ex_branch_i        (ex_branch_i),
        .ex_branch_target_i (ex_branch_target_i),
        .pc_o               (pc_o),
        .pc_plus4_o         (pc_plus4_o),
        .flush_ifid_o       (flush_ifid_o),
        .flush_idex_o       (flush_idex_o),
`ifdef PC_REDIRECT_STATS_EN
        .br_taken_cnt_o     (br_taken_cnt_o),
        .flush_cyc_cnt_o    (flush_cyc_cnt_o),
`endif
        .redirect_pend_o    (redirect_pend_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_i            = 1'b0;
        id_jump_i          = 1'b0;
        id_jump_target_i   = 32'd0;
        ex_is_branch_i     = 1'b0;
        ex_branch_i        = 1'b0;
        ex_branch_target_i = 32'd0;
    endtask

    task automatic branch(input logic [31:0] tgt);
        ex_is_branch_i     = 1'b1;
        ex_branch_i        = 1'b1;
        ex_branch_target_i = tgt;
    endtask

    task automatic jump(input logic [31:0] tgt);
        id_jump_i        = 1'b1;
        id_jump_target_i = tgt;
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ready_i = 1'b1;
        idle();
        #12;
        // T1 reset and sequential fetch
        check("rst_pc", pc_o, 32'h0040_0000);
        check("rst_pend", {31'd0, redirect_pend_o}, 32'd0);
        check("rst_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd0);
        rst_n = 1'b1;
        tick(); check("t1_pc1", pc_o, 32'h0040_0004);
        tick(); check("t1_pc2", pc_o, 32'h0040_0008);
        tick(); tick(); check("t1_pc4", pc_o, 32'h0040_0010);

        // T2 taken branch; not-taken branch flag alone does nothing
        ex_is_branch_i = 1'b1; #1;
        check("t2_nt_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd0);
        branch(32'h0040_0100); #1;
        check("t2_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd3);
        check("t2_plus4", pc_plus4_o, 32'h0040_0014);
        tick(); idle(); #1;
        check("t2_pc", pc_o, 32'h0040_0100);
        check("t2_flush_off", {30'd0, flush_ifid_o, flush_idex_o}, 32'd0);

        // T3 branch beats simultaneous jump
        branch(32'h0040_0200); jump(32'h0040_0800); #1;
        check("t3_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd3);
        tick(); idle();
        check("t3_pc", pc_o, 32'h0040_0200);

        // T4 stall holds, branch overrides stall, plain jump flushes IF/ID only
        stall_i = 1'b1;
        tick(); tick();
        check("t4_hold", pc_o, 32'h0040_0200);
        branch(32'h0040_0300);
        tick(); idle();
        check("t4_br_stall", pc_o, 32'h0040_0300);
        jump(32'h0040_0500); #1;
        check("t4_j_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd2);
        tick(); idle();
        check("t4_j_pc", pc_o, 32'h0040_0500);

        // T5 jump while memory not ready is held and replayed
        imem_ready_i = 1'b0; jump(32'h0040_1000);
        tick(); idle();
        check("t5_pend", {31'd0, redirect_pend_o}, 32'd1);
        tick(); tick();
        check("t5_hold", pc_o, 32'h0040_0500);
        check("t5_pend3", {31'd0, redirect_pend_o}, 32'd1);
        imem_ready_i = 1'b1; #1;
        check("t5_replay_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd2);
        tick();
        check("t5_pc", pc_o, 32'h0040_1000);
        check("t5_pend_clr", {31'd0, redirect_pend_o}, 32'd0);

        // T5b branch during PEND replaces the target; later jump is ignored
        imem_ready_i = 1'b0; jump(32'h0040_2000);
        tick(); idle();
        branch(32'h0040_3000); #1;
        check("t5b_flush", {30'd0, flush_ifid_o, flush_idex_o}, 32'd3);
        tick(); idle();
        jump(32'h0040_5000); #1;
        check("t5b_j_ignored", {30'd0, flush_ifid_o, flush_idex_o}, 32'd0);
        tick(); idle();
        check("t5b_hold", pc_o, 32'h0040_1000);
        imem_ready_i = 1'b1;
        tick();
        check("t5b_pc", pc_o, 32'h0040_3000);

        // T6 wrap at top of address space
        jump(32'hFFFF_FFFC);
        tick(); idle();
        check("t6_top", pc_o, 32'hFFFF_FFFC);
        check("t6_plus4", pc_plus4_o, 32'h0000_0000);
        tick();
        check("t6_wrap", pc_o, 32'h0000_0000);

        // T6 reset during PEND discards the latched target
        imem_ready_i = 1'b0; jump(32'h0040_6000);
        tick(); idle();
        check("t6_pend", {31'd0, redirect_pend_o}, 32'd1);
        #2 rst_n = 1'b0; #1;
        check("t6_rst_pc", pc_o, 32'h0040_0000);
        check("t6_rst_pend", {31'd0, redirect_pend_o}, 32'd0);
        rst_n = 1'b1; imem_ready_i = 1'b1;
        tick();
        check("t6_after_rst", pc_o, 32'h0040_0004);

`ifdef PC_REDIRECT_STATS_EN
        for (int i = 0; i < 3; i++) begin
            branch(32'h0040_7000 + 32'(i * 16));
            tick();
        end
        idle();
        jump(32'h0040_8000);
        tick(); idle();
        check("stats_br", br_taken_cnt_o, 32'd3);
        check("stats_flush", flush_cyc_cnt_o, 32'd4);
        check("stats_pc", pc_o, 32'h0040_8000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
